hazard_unit: RTL and testbench
==============================

# hazard_unit

Stall generator that drives `is_hazard_detected` into the instruction decoder. It sits beside the ID stage and watches the decode-stage instruction, the EX-stage load, the data-cache ready status and the occupancy of the multi-cycle complex ALU. It tracks the complex ALU's multi-cycle mul-c/div-c operations with an internal counter. From these inputs it produces the pipeline freeze controls for PC and IF/ID.

## Interface

Parameters:
- `MULC_CYCLES`, default 4: total complex-ALU occupancy of mul-c in cycles, including the issue cycle. Must be ≥1.
- `DIVC_CYCLES`, default 8: total complex-ALU occupancy of div-c in cycles, including the issue cycle. Must be ≥1.
- `CNT_W`, default 4: occupancy counter width. Must satisfy 2^CNT_W > max(MULC_CYCLES, DIVC_CYCLES).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `id_valid`, input, 1: the ID stage holds a real, non-flushed instruction.
- `id_opcode`, input, 6: opcode of the ID instruction.
- `id_funct`, input, 6: funct field of the ID instruction.
- `id_rs`, input, 5: rs of the ID instruction.
- `id_rt`, input, 5: rt of the ID instruction.
- `ex_load`, input, 1: the EX instruction is lw or lb.
- `ex_rt`, input, 5: destination register of the EX load.
- `cache_stall`, input, 1: the data cache is not ready this cycle.
- `is_hazard_detected`, output, 1: decoder squash; forces all decoder controls to their defaults.
- `pc_write_en`, output, 1: PC register update enable.
- `ifid_write_en`, output, 1: IF/ID register update enable.
- `cx_busy`, output, 1: the complex ALU is occupied by an earlier mul-c or div-c.

## Operation

Decode of the ID instruction, all terms gated by `id_valid`:
- `uses_rs` is 0 for j, jal and syscall. It is 1 for everything else.
- `uses_rt` is 1 for R-format (except jr and syscall), beq, bne and sw/sb. It is 0 otherwise.
- `is_cx` is asserted for opcodes 6'b101100 through 6'b110111.
- `is_long` is asserted for mul-c (6'b101110) and div-c (6'b101111).

Hazard terms:
- `lu` (load-use) = `ex_load` && `ex_rt` != 0 && ((`uses_rs` && `ex_rt` == `id_rs`) || (`uses_rt` && `ex_rt` == `id_rt`)).
- `cx` = `is_cx` && `cx_busy`.
- `is_hazard_detected` = `lu` || `cx` || `cache_stall`.
- `pc_write_en` = `ifid_write_en` = !`is_hazard_detected`.

Occupancy counter `cnt`:
- Issue condition: `is_long` && !`is_hazard_detected`.
- On issue, `cnt` loads CYCLES−1, using `MULC_CYCLES` or `DIVC_CYCLES` as appropriate.
- Otherwise, if `cnt` != 0, `cnt` decrements by 1. It decrements regardless of `cache_stall`.
- `cnt` saturates at 0. It never wraps.
- `cx_busy` = (`cnt` != 0).
- States are implied by the counter: IDLE when `cnt` == 0, BUSY when `cnt` != 0.
  - IDLE→BUSY on an issue with CYCLES ≥ 2.
  - BUSY→IDLE when `cnt` decrements to 0.
  - BUSY is never re-entered from BUSY, because `cx` blocks any issue while busy.

Boundary conditions:
- CYCLES = 1: issue loads 0, so the unit never goes busy.
- `cnt` == 1 with a complex instruction in ID: that cycle stalls. The instruction issues in the next cycle.
- Non-complex instructions proceed normally while busy.
- Several hazard terms active at once: the output is a plain OR. No term has priority, and no term is counted.
- `id_valid` = 0: `lu` and `cx` are 0 and nothing issues. `cache_stall` still stalls.
- `rst_n` asserted mid-operation: `cnt` clears to 0 immediately, asynchronously.

## Timing

- Reset values while `rst_n` = 0: `cnt` = 0, `cx_busy` = 0, `is_hazard_detected` = 0, `pc_write_en` = 0, `ifid_write_en` = 0. The pipeline is frozen during reset.
- After `rst_n` deasserts, outputs follow the combinational equations.
- Hazard outputs are combinational from inputs and `cnt`, with zero-cycle latency. No input-to-output path passes through another register.
- Occupancy: an issue at edge t gives `cx_busy` = 1 for cycles t+1 through t+CYCLES−1. It drops at edge t+CYCLES−1.

## Structure

- Shared package `cpu_pkg` holds the `OP_*` opcode constants (R-format, j, jal, beq, bne, sw, sb, complex range), the `FN_JR` and `FN_SYSCALL` funct codes, and the default cycle counts. The decoder uses the same package.
- One natural sub-module, `cx_occupancy_counter`:
  - Inputs: load, load value, clock, reset.
  - Output: busy.

## Test plan

- Load-use: `ex_load` = 1, `ex_rt` = 5, ID is add with rs = 5 → `is_hazard_detected` = 1 and `pc_write_en` = 0 for exactly that cycle. With `ex_rt` = 0 → no stall.
- rt not used: `ex_rt` = 5, ID is addi with rt = 5 → no stall. The same case with sw → stall.
- mul-c with `MULC_CYCLES` = 4, followed by add-c → `cx_busy` high for 3 cycles. add-c stalls 3 cycles and issues in the 4th. An interleaved add (non-complex) is never stalled.
- div-c issued while `cache_stall` = 1 → no issue and `cnt` stays 0. When `cache_stall` drops → issue, then `cx_busy` high for 7 cycles.
- `rst_n` pulsed low with `cnt` = 5 → `cx_busy` = 0 immediately, with no clock needed. All enables are 0 during reset.
- load-use, `cx` and `cache_stall` all active in the same cycle → a single stall cycle, and `cnt` still decrements.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU opcode/funct constants and complex-ALU default timing.
// Used by the hazard unit and the instruction decoder.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_CX_LO = 6'b101100;
  localparam logic [5:0] OP_CX_HI = 6'b110111;
  localparam logic [5:0] OP_MULC  = 6'b101110;
  localparam logic [5:0] OP_DIVC  = 6'b101111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  localparam int MULC_CYCLES_DEF = 4;
  localparam int DIVC_CYCLES_DEF = 8;

  function automatic logic op_is_cx(input logic [5:0] op);
    return (op >= OP_CX_LO) && (op <= OP_CX_HI);
  endfunction

endpackage

// File: rtl/cx_occupancy_counter.sv
// Complex-ALU occupancy down-counter: load sets remaining busy cycles,
// otherwise counts down and saturates at zero; busy while nonzero.
module cx_occupancy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// ID-stage stall generator: load-use, complex-ALU occupancy and cache stall
// combine into a decoder squash plus PC and IF/ID freeze.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int MULC_CYCLES = MULC_CYCLES_DEF,
  parameter int DIVC_CYCLES = DIVC_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_load,
  input  logic [4:0] ex_rt,
  input  logic       cache_stall,
  output logic       is_hazard_detected,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       cx_busy
);

  localparam logic [CNT_W-1:0] MULC_LOAD = CNT_W'(MULC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIVC_LOAD = CNT_W'(DIVC_CYCLES - 1);

  logic             is_r, is_jr, is_syscall;
  logic             uses_rs, uses_rt, is_cx, is_long;
  logic             lu, cx, stall;
  logic             issue;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    is_r       = (id_opcode == OP_RTYPE);
    is_jr      = is_r && (id_funct == FN_JR);
    is_syscall = is_r && (id_funct == FN_SYSCALL);

    uses_rs = id_valid && !((id_opcode == OP_J) || (id_opcode == OP_JAL) || is_syscall);
    uses_rt = id_valid && ((is_r && !is_jr && !is_syscall) ||
                           (id_opcode == OP_BEQ) || (id_opcode == OP_BNE) ||
                           (id_opcode == OP_SW)  || (id_opcode == OP_SB));
    is_cx   = id_valid && op_is_cx(id_opcode);
    is_long = id_valid && ((id_opcode == OP_MULC) || (id_opcode == OP_DIVC));

    lu = ex_load && (ex_rt != 5'd0) &&
         ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
    cx    = is_cx && cx_busy;
    stall = lu || cx || cache_stall;

    issue    = is_long && !stall;
    load_val = (id_opcode == OP_MULC) ? MULC_LOAD : DIVC_LOAD;
  end

  // Reset freezes the pipeline: enables low, squash low.
  assign is_hazard_detected = rst_n && stall;
  assign pc_write_en        = rst_n && !stall;
  assign ifid_write_en      = rst_n && !stall;

  cx_occupancy_counter #(
    .CNT_W(CNT_W)
  ) u_cx_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (issue),
    .load_val(load_val),
    .busy    (cx_busy)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with default cycle counts (mul-c 4, div-c 8).
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [5:0] id_funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_load;
  logic [4:0] ex_rt;
  logic       cache_stall;
  logic       is_hazard_detected;
  logic       pc_write_en;
  logic       ifid_write_en;
  logic       cx_busy;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_ADDC = 6'b101100;
  localparam logic [5:0] OPC_MULC = 6'b101110;
  localparam logic [5:0] OPC_DIVC = 6'b101111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_JR_C  = 6'b001000;
  localparam logic [5:0] FN_SYS_C = 6'b001100;

  hazard_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_opcode         (id_opcode),
    .id_funct          (id_funct),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .ex_load           (ex_load),
    .ex_rt             (ex_rt),
    .cache_stall       (cache_stall),
    .is_hazard_detected(is_hazard_detected),
    .pc_write_en       (pc_write_en),
    .ifid_write_en     (ifid_write_en),
    .cx_busy           (cx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
    id_valid  = v;
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  task automatic idle();
    drive_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
    ex_load     = 1'b0;
    ex_rt       = 5'd0;
    cache_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cache_stall = 1'b1;
    #3;
    chk("rst_busy", cx_busy, 0);
    chk("rst_haz", is_hazard_detected, 0);
    chk("rst_pc_we", pc_write_en, 0);
    chk("rst_ifid_we", ifid_write_en, 0);
    cache_stall = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    sample();
    chk("idle_pc_we", pc_write_en, 1);
    chk("idle_haz", is_hazard_detected, 0);
    step();

    // Load-use on rs, one cycle only
    ex_load = 1'b1; ex_rt = 5'd5;
    drive_id(1'b1, OPC_R, FN_ADD, 5'd5, 5'd1);
    sample();
    chk("lu_rs_haz", is_hazard_detected, 1);
    chk("lu_rs_pc_we", pc_write_en, 0);
    chk("lu_rs_ifid_we", ifid_write_en, 0);
    step();
    ex_load = 1'b0;
    sample();
    chk("lu_clear_haz", is_hazard_detected, 0);
    chk("lu_clear_pc_we", pc_write_en, 1);
    step();

    ex_load = 1'b1; ex_rt = 5'd0;
    drive_id(1'b1, OPC_R, FN_ADD, 5'd0, 5'd0);
    sample();
    chk("lu_r0_haz", is_hazard_detected, 0);
    step();

    // rt usage by instruction class
    ex_rt = 5'd5;
    drive_id(1'b1, OPC_ADDI, 6'd0, 5'd1, 5'd5);
    sample();
    chk("addi_rt_haz", is_hazard_detected, 0);
    drive_id(1'b1, OPC_SW, 6'd0, 5'd1, 5'd5);
    #1 chk("sw_rt_haz", is_hazard_detected, 1);
    drive_id(1'b1, OPC_BEQ, 6'd0, 5'd1, 5'd5);
    #1 chk("beq_rt_haz", is_hazard_detected, 1);
    drive_id(1'b1, OPC_J, 6'd0, 5'd5, 5'd5);
    #1 chk("j_no_rs_haz", is_hazard_detected, 0);
    drive_id(1'b1, OPC_R, FN_SYS_C, 5'd5, 5'd5);
    #1 chk("syscall_haz", is_hazard_detected, 0);
    drive_id(1'b1, OPC_R, FN_JR_C, 5'd1, 5'd5);
    #1 chk("jr_rt_haz", is_hazard_detected, 0);
    drive_id(1'b0, OPC_R, FN_ADD, 5'd5, 5'd5);
    #1 chk("invalid_lu_haz", is_hazard_detected, 0);
    step();
    idle();

    // mul-c then add-c with an interleaved add
    drive_id(1'b1, OPC_MULC, 6'd0, 5'd1, 5'd2);
    sample();
    chk("mulc_issue_haz", is_hazard_detected, 0);
    chk("mulc_pre_busy", cx_busy, 0);
    step();
    drive_id(1'b1, OPC_ADDC, 6'd0, 5'd3, 5'd4);
    sample();
    chk("mulc_c1_busy", cx_busy, 1);
    chk("addc_c1_haz", is_hazard_detected, 1);
    step();
    drive_id(1'b1, OPC_R, FN_ADD, 5'd3, 5'd4);
    sample();
    chk("mulc_c2_busy", cx_busy, 1);
    chk("add_while_busy_haz", is_hazard_detected, 0);
    step();
    drive_id(1'b1, OPC_ADDC, 6'd0, 5'd3, 5'd4);
    sample();
    chk("mulc_c3_busy", cx_busy, 1);
    chk("addc_c3_haz", is_hazard_detected, 1);
    step();
    sample();
    chk("mulc_c4_busy", cx_busy, 0);
    chk("addc_c4_haz", is_hazard_detected, 0);
    step();
    idle();

    // div-c held off by cache stall, then issues
    drive_id(1'b1, OPC_DIVC, 6'd0, 5'd1, 5'd2);
    cache_stall = 1'b1;
    sample();
    chk("divc_cs_haz", is_hazard_detected, 1);
    step();
    sample();
    chk("divc_cs_no_issue", cx_busy, 0);
    cache_stall = 1'b0;
    #1 chk("divc_go_haz", is_hazard_detected, 0);
    step();
    idle();
    for (int i = 0; i < 7; i++) begin
      sample();
      chk($sformatf("divc_busy_%0d", i + 1), cx_busy, 1);
      step();
    end
    sample();
    chk("divc_done", cx_busy, 0);
    step();

    // Asynchronous reset while cnt = 5
    drive_id(1'b1, OPC_DIVC, 6'd0, 5'd1, 5'd2);
    step();
    idle();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", cx_busy, 0);
    chk("arst_pc_we", pc_write_en, 0);
    chk("arst_ifid_we", ifid_write_en, 0);
    chk("arst_haz", is_hazard_detected, 0);
    sample();
    rst_n = 1'b1;
    step();
    sample();
    chk("post_arst_busy", cx_busy, 0);
    step();

    // All hazard terms at once; counter keeps draining
    drive_id(1'b1, OPC_MULC, 6'd0, 5'd1, 5'd2);
    step();
    ex_load = 1'b1; ex_rt = 5'd7; cache_stall = 1'b1;
    drive_id(1'b1, OPC_ADDC, 6'd0, 5'd7, 5'd0);
    sample();
    chk("all_haz", is_hazard_detected, 1);
    chk("all_pc_we", pc_write_en, 0);
    chk("all_busy", cx_busy, 1);
    step();
    idle();
    sample();
    chk("all_next_haz", is_hazard_detected, 0);
    chk("all_next_busy", cx_busy, 1);
    step();
    sample();
    chk("all_drain1_busy", cx_busy, 1);
    step();
    sample();
    chk("all_drain0_busy", cx_busy, 0);

    // Invalid mul-c never issues
    drive_id(1'b0, OPC_MULC, 6'd0, 5'd1, 5'd2);
    step();
    sample();
    chk("invalid_mulc_busy", cx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
